// File: rtl/brlwe_pkg.sv
// Shared constants and types for the BRLWE load path and decryption core.
package brlwe_pkg;

    localparam int N  = 256;
    localparam int QW = 8;
    localparam int AW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // One serial beat; field order matches the packed RAM word {r2, c1, c2}.
    typedef struct packed {
        logic          r2;
        logic [QW-1:0] c1;
        logic [QW-1:0] c2;
    } beat_t;

endpackage

// File: rtl/brlwe_coef_ram.sv
// Single-write, registered-read coefficient array; the read register clears on reset
// so the consumer sees zeros until its first read.
module brlwe_coef_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 17
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read that collides with a write returns the previous contents.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/brlwe_load_rx.sv
// Core-side receiver for the BRLWE serial load protocol: buffers one frame,
// launches the datapath on start and holds the buffer until done.
module brlwe_load_rx #(
    parameter int N  = brlwe_pkg::N,
    parameter int QW = brlwe_pkg::QW,
    parameter int AW = brlwe_pkg::AW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic          start,
    input  logic          r2_in,
    input  logic [QW-1:0] c1_in,
    input  logic [QW-1:0] c2_in,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          done,
    input  logic          clr_err,
    output logic          rd_valid,
    output logic          rd_r2,
    output logic [QW-1:0] rd_c1,
    output logic [QW-1:0] rd_c2,
    output logic          go,
    output logic          full,
    output logic          busy,
    output logic          err_short,
    output logic          err_long,
    output logic          err_seq,
    output logic [15:0]   frame_cnt
);

    import brlwe_pkg::*;

    localparam int DW = 1 + 2*QW;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          we;
    logic          cnt_inc;
    logic          ev_short, ev_long, ev_seq;
    logic          go_q, go_d;
    logic          rd_valid_q;
    logic          err_short_q, err_long_q, err_seq_q;
    logic [15:0]   frame_cnt_q;
    logic [DW-1:0] rd_word;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        we       = 1'b0;
        cnt_inc  = 1'b0;
        ev_short = 1'b0;
        ev_long  = 1'b0;
        ev_seq   = 1'b0;
        case (state_q)
            IDLE: begin
                ev_seq = start;
                if (load) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (load) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == AW'(N-1)) begin
                        cnt_inc = 1'b1;
                        state_d = start ? HOLD : ARMED;
                    end else begin
                        ev_seq = start;
                    end
                end else begin
                    ev_short = 1'b1;
                    ev_seq   = start;
                    wr_ptr_d = '0;
                    state_d  = IDLE;
                end
            end
            ARMED: begin
                ev_long = load;
                if (start) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                ev_long = load;
                ev_seq  = start;
                if (done) begin
                    wr_ptr_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        go_d = (state_d == HOLD) && (state_q != HOLD);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            go_q        <= 1'b0;
            rd_valid_q  <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_seq_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            go_q        <= go_d;
            rd_valid_q  <= rd_en;
            // A new event outranks a simultaneous clear.
            err_short_q <= ev_short | (err_short_q & ~clr_err);
            err_long_q  <= ev_long  | (err_long_q  & ~clr_err);
            err_seq_q   <= ev_seq   | (err_seq_q   & ~clr_err);
            if (cnt_inc) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    brlwe_coef_ram #(
        .DEPTH (N),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (we & resetn),
        .waddr  (wr_ptr_q),
        .wdata  ({r2_in, c1_in, c2_in}),
        .re     (rd_en),
        .raddr  (rd_addr),
        .rdata  (rd_word)
    );

    assign {rd_r2, rd_c1, rd_c2} = rd_word;
    assign rd_valid  = rd_valid_q;
    assign go        = go_q;
    assign full      = (state_q == ARMED) || (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign err_seq   = err_seq_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_brlwe_load_rx.sv
// Randomized bench for brlwe_load_rx against a frame-level reference model.
module tb_brlwe_load_rx;

    import brlwe_pkg::*;

    logic          clk = 1'b0;
    logic          resetn, load, start, r2_in, rd_en, done, clr_err;
    logic [QW-1:0] c1_in, c2_in;
    logic [AW-1:0] rd_addr;
    logic          rd_valid, rd_r2, go, full, busy, err_short, err_long, err_seq;
    logic [QW-1:0] rd_c1, rd_c2;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    brlwe_load_rx dut (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .start     (start),
        .r2_in     (r2_in),
        .c1_in     (c1_in),
        .c2_in     (c2_in),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .done      (done),
        .clr_err   (clr_err),
        .rd_valid  (rd_valid),
        .rd_r2     (rd_r2),
        .rd_c1     (rd_c1),
        .rd_c2     (rd_c2),
        .go        (go),
        .full      (full),
        .busy      (busy),
        .err_short (err_short),
        .err_long  (err_long),
        .err_seq   (err_seq),
        .frame_cnt (frame_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a count of beats received plus "complete" and
    // "launched" flags; the buffer is a plain array with a written-mask.
    beat_t       m_mem [N];
    bit          m_wr  [N];
    int          m_beats;
    bit          m_have, m_launched, m_go;
    bit          m_es, m_el, m_eq, m_rv, m_rd_known;
    logic [15:0] m_cnt;
    beat_t       m_rd;
    beat_t       sent0;

    task automatic model_reset();
        m_beats = 0; m_have = 0; m_launched = 0; m_go = 0;
        m_es = 0; m_el = 0; m_eq = 0; m_cnt = '0;
        m_rv = 0; m_rd = '0; m_rd_known = 1;
    endtask

    task automatic model_step();
        bit    e_s, e_l, e_q;
        beat_t b;
        e_s = 0; e_l = 0; e_q = 0;
        b = '{r2: r2_in, c1: c1_in, c2: c2_in};
        m_rv = rd_en;
        if (rd_en) begin
            m_rd_known = m_wr[rd_addr];
            m_rd       = m_mem[rd_addr];
        end
        m_go = 0;
        if (!m_have) begin
            if (load) begin
                m_mem[m_beats] = b;
                m_wr[m_beats]  = 1;
                m_beats++;
                if (m_beats == N) begin
                    m_have = 1;
                    m_cnt  = m_cnt + 16'd1;
                    if (start) begin m_launched = 1; m_go = 1; end
                end else if (start) begin
                    e_q = 1;
                end
            end else begin
                if (m_beats > 0) e_s = 1;
                if (start) e_q = 1;
                m_beats = 0;
            end
        end else if (!m_launched) begin
            if (load) e_l = 1;
            if (start) begin m_launched = 1; m_go = 1; end
        end else begin
            if (load) e_l = 1;
            if (start) e_q = 1;
            if (done) begin m_have = 0; m_launched = 0; m_beats = 0; end
        end
        m_es = e_s | (m_es & !clr_err);
        m_el = e_l | (m_el & !clr_err);
        m_eq = e_q | (m_eq & !clr_err);
    endtask

    task automatic cycle();
        if (resetn) model_step();
        else model_reset();
        @(posedge clk);
        #1;
        check("go", go, m_go);
        check("full", full, m_have);
        check("busy", busy, (m_have || m_beats != 0));
        check("err_short", err_short, m_es);
        check("err_long", err_long, m_el);
        check("err_seq", err_seq, m_eq);
        check("frame_cnt", frame_cnt, m_cnt);
        check("rd_valid", rd_valid, m_rv);
        if (m_rd_known) check("rd_data", {rd_r2, rd_c1, rd_c2}, m_rd);
        load = 0; start = 0; done = 0; clr_err = 0; rd_en = 0; resetn = 1;
    endtask

    task automatic rand_beat();
        r2_in = 1'($urandom);
        c1_in = QW'($urandom);
        c2_in = QW'($urandom);
    endtask

    task automatic rand_read();
        rd_en   = 1'($urandom);
        rd_addr = AW'($urandom);
    endtask

    // Full random frame; start is raised on beat start_at (-1 for none).
    task automatic send_frame(input int start_at);
        for (int i = 0; i < N; i++) begin
            load  = 1;
            start = (i == start_at);
            rand_beat();
            if (i == 0) sent0 = '{r2: r2_in, c1: c1_in, c2: c2_in};
            rand_read();
            cycle();
        end
    endtask

    initial begin
        logic [15:0] cnt0;
        resetn = 0; load = 0; start = 0; done = 0; clr_err = 0; rd_en = 0;
        r2_in = 0; c1_in = '0; c2_in = '0; rd_addr = '0;
        for (int i = 0; i < N; i++) m_wr[i] = 0;
        model_reset();

        repeat (3) begin resetn = 0; cycle(); end
        check("rst_outs", {go, full, busy, err_short, err_long, err_seq, rd_valid}, 0);
        check("rst_cnt", frame_cnt, 0);

        // Nominal frame, start on the last beat.
        for (int i = 0; i < N; i++) begin
            logic [AW-1:0] iv;
            iv    = AW'(i);
            load  = 1;
            start = (i == N-1);
            r2_in = iv[0];
            c1_in = QW'(i);
            c2_in = QW'(255 - i);
            rand_read();
            cycle();
        end
        check("nom_go", go, 1);
        check("nom_cnt", frame_cnt, 1);
        cycle();
        check("nom_go_once", go, 0);
        rd_en = 1; rd_addr = 8'h10; cycle();
        check("nom_rd_c1", rd_c1, 8'h10);
        check("nom_rd_c2", rd_c2, 8'hEF);
        check("nom_rd_r2", rd_r2, 0);
        done = 1; cycle();
        check("nom_release", busy, 0);

        // Deferred start.
        send_frame(-1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("def_full", full, 1);
            check("def_nogo", go, 0);
        end
        start = 1; cycle();
        check("def_go", go, 1);
        check("def_noerr", {err_short, err_long, err_seq}, 0);
        done = 1; cycle();

        // Short frame, then a clean frame counts exactly once.
        for (int i = 0; i < 100; i++) begin load = 1; rand_beat(); cycle(); end
        cycle();
        check("short_err", err_short, 1);
        check("short_idle", busy, 0);
        cnt0 = m_cnt;
        send_frame(N-1);
        check("short_cnt", frame_cnt, 32'(cnt0 + 16'd1));
        done = 1; cycle();

        // Early start, overrun in ARMED, then clear.
        clr_err = 1; cycle();
        check("ovr_clr0", {err_short, err_long, err_seq}, 0);
        send_frame(50);
        check("ovr_armed", full, 1);
        load = 1; rand_beat(); cycle();
        check("ovr_seq", err_seq, 1);
        check("ovr_long", err_long, 1);
        rd_en = 1; rd_addr = '0; cycle();
        check("ovr_beat0", {rd_r2, rd_c1, rd_c2}, sent0);
        clr_err = 1; cycle();
        check("ovr_clr", {err_long, err_seq}, 0);
        start = 1; cycle();
        check("ovr_go", go, 1);
        // done and load together: done wins, beat discarded but flagged.
        done = 1; load = 1; rand_beat(); cycle();
        check("ovr_done_wins", busy, 0);

        // Release, then reset in the middle of a frame.
        clr_err = 1; cycle();
        send_frame(N-1);
        done = 1; cycle();
        check("rel_idle", busy, 0);
        for (int i = 0; i <= 128; i++) begin
            load = 1; rand_beat();
            if (i == 128) resetn = 0;
            cycle();
        end
        check("mid_rst_outs", {go, full, busy, err_short, err_long, err_seq, rd_valid}, 0);
        check("mid_rst_rd", {rd_r2, rd_c1, rd_c2}, 0);
        check("mid_rst_cnt", frame_cnt, 0);
        repeat (3) cycle();

        // Frame counter wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        check("wrap_pre", frame_cnt, 16'hFFFF);
        send_frame(N-1);
        check("wrap_cnt", frame_cnt, 0);
        done = 1; cycle();

        // Random protocol traffic.
        for (int k = 0; k < 600; k++) begin
            load    = ($urandom_range(63) != 0);
            start   = ($urandom_range(15) == 0);
            done    = ($urandom_range(7) == 0);
            clr_err = ($urandom_range(15) == 0);
            rand_beat();
            rand_read();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
